// File: rtl/capture_trigger_pkg.sv
// Shared types and defaults for the logic-analyser capture front end.
package capture_trigger_pkg;

  // Default geometry: 8 channels packed four-to-a-word downstream.
  localparam int LVDS_LEN_DEF = 8;
  localparam int DATA_LEN_DEF = 32;
  localparam int DIV_W_DEF    = 16;
  localparam int CNT_W_DEF    = 24;

  // Byte index of the last byte in a 32-bit word.
  localparam logic [1:0] LAST_BYTE_IDX = 2'd3;

  // Acquisition state machine encoding (matches the host register map).
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/capture_trigger_sample_rate_div.sv
// Programmable sample strobe: one stb every div+1 clocks, restartable by clr.
module sample_rate_div
  import capture_trigger_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             stb
);

  logic [DIV_W-1:0] r_cnt;

  // Count 0..div and wrap; clr forces the count to 0 so the next cycle strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (r_cnt >= div) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Strobe whenever the count sits at zero; div=0 strobes every cycle.
  assign stb = (r_cnt == '0);

endmodule

// File: rtl/capture_trigger.sv
// Capture front end: synchronises the channels, waits for a mask/value
// trigger, then streams whole 32-bit words of bytes to the packer.
module capture_trigger
  import capture_trigger_pkg::*;
#(
  parameter int LVDS_LEN = LVDS_LEN_DEF,
  parameter int DIV_W    = DIV_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LVDS_LEN-1:0] sample_in,
  input  logic                arm,
  input  logic                abort,
  input  logic [DIV_W-1:0]    div,
  input  logic [LVDS_LEN-1:0] trig_mask,
  input  logic [LVDS_LEN-1:0] trig_value,
  input  logic                trig_edge,
  input  logic [CNT_W-1:0]    capture_len,
  output logic                valid_out,
  output logic [LVDS_LEN-1:0] data_out,
  output logic                busy,
  output logic                armed,
  output logic                done
);

  // Synchroniser stages; r_sync2 is the sample value seen by all logic.
  logic [LVDS_LEN-1:0] r_sync1;
  logic [LVDS_LEN-1:0] r_sync2;

  // Configuration captured on an accepted arm.
  logic [DIV_W-1:0]    r_div_q;
  logic [LVDS_LEN-1:0] r_tmask_q;
  logic [LVDS_LEN-1:0] r_tval_q;
  logic                r_edge_q;
  logic [CNT_W-1:0]    r_len_q;

  // Acquisition state, counters and output registers.
  state_t              r_state;
  logic                r_prev_match;
  logic [1:0]          r_byte_idx;
  logic [CNT_W-1:0]    r_word_cnt;
  logic                r_abort_pend;
  logic                r_valid;
  logic [LVDS_LEN-1:0] r_data;

  logic [LVDS_LEN-1:0] w_ch_miss;
  logic                w_match;
  logic                w_trig;
  logic                w_stb;
  logic                w_arm_ok;
  logic                w_last_word;

  // Two-flop synchroniser on the asynchronous channel pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sample_in;
      r_sync2 <= r_sync1;
    end
  end

  // Per-channel trigger miss: a masked channel whose level differs from the target.
  genvar gi;
  generate
    for (gi = 0; gi < LVDS_LEN; gi++) begin : g_chan
      assign w_ch_miss[gi] = r_tmask_q[gi] & (r_sync2[gi] ^ r_tval_q[gi]);
    end
  endgenerate

  assign w_match = ~|w_ch_miss;

  // Edge mode needs a non-matching strobe before the matching one.
  assign w_trig = r_edge_q ? (w_match & ~r_prev_match) : w_match;

  // Arm is honoured only from IDLE or DONE, and abort in the same cycle wins.
  assign w_arm_ok = arm && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // The byte with index 3 of this word finishes the capture.
  assign w_last_word = (r_word_cnt == (r_len_q - 1'b1));

  sample_rate_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_arm_ok),
    .div   (r_div_q),
    .stb   (w_stb)
  );

  // Latch configuration on an accepted arm; ignored at all other times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_q   <= '0;
      r_tmask_q <= '0;
      r_tval_q  <= '0;
      r_edge_q  <= 1'b0;
      r_len_q   <= '0;
    end else if (w_arm_ok) begin
      r_div_q   <= div;
      r_tmask_q <= trig_mask;
      r_tval_q  <= trig_value;
      r_edge_q  <= trig_edge;
      r_len_q   <= capture_len;
    end
  end

  // Acquisition FSM with byte/word counters and the registered byte output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_prev_match <= 1'b0;
      r_byte_idx   <= 2'd0;
      r_word_cnt   <= '0;
      r_abort_pend <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_arm_ok) begin
        r_state      <= ST_ARMED;
        r_prev_match <= 1'b1;
        r_byte_idx   <= 2'd0;
        r_word_cnt   <= '0;
        r_abort_pend <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_abort_pend <= 1'b0;
          end

          ST_ARMED: begin
            if (abort) begin
              r_state <= ST_IDLE;
            end else if (w_stb) begin
              r_prev_match <= w_match;
              if (w_trig) begin
                if (r_len_q == '0) begin
                  r_state <= ST_DONE;
                end else begin
                  // The trigger sample itself is byte 0 of the capture.
                  r_valid    <= 1'b1;
                  r_data     <= r_sync2;
                  r_byte_idx <= 2'd1;
                  r_state    <= ST_CAPTURE;
                end
              end
            end
          end

          ST_CAPTURE: begin
            if (abort && (r_byte_idx == 2'd0)) begin
              // On a word boundary the stream can stop immediately.
              r_state      <= ST_IDLE;
              r_abort_pend <= 1'b0;
            end else begin
              // Mid-word abort: finish the word so the packer stays aligned.
              if (abort) begin
                r_abort_pend <= 1'b1;
              end
              if (w_stb) begin
                r_valid    <= 1'b1;
                r_data     <= r_sync2;
                r_byte_idx <= r_byte_idx + 2'd1;
                if (r_byte_idx == LAST_BYTE_IDX) begin
                  r_word_cnt <= r_word_cnt + 1'b1;
                  if (r_abort_pend || abort) begin
                    r_state      <= ST_IDLE;
                    r_abort_pend <= 1'b0;
                  end else if (w_last_word) begin
                    r_state <= ST_DONE;
                  end
                end
              end
            end
          end

          ST_DONE: begin
            if (abort) begin
              r_state <= ST_IDLE;
            end
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign valid_out = r_valid;
  assign data_out  = r_data;
  assign busy      = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
  assign armed     = (r_state == ST_ARMED);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_capture_trigger.sv
// Self-checking bench for capture_trigger: table-driven captures plus
// hand-written trigger/abort/reset sequences, bytes checked via a scoreboard.
module tb_capture_trigger;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  sample_in = 8'h00;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] div = 16'h0;
  logic [7:0]  trig_mask = 8'h00;
  logic [7:0]  trig_value = 8'h00;
  logic        trig_edge = 1'b0;
  logic [23:0] capture_len = 24'h0;
  logic        valid_out;
  logic [7:0]  data_out;
  logic        busy;
  logic        armed;
  logic        done;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int byte_cnt = 0;
  logic sb_en = 1'b1;

  // Pin pattern: cycle number, with selected channels forced to a level.
  logic [7:0] force_mask = 8'h00;
  logic [7:0] force_val = 8'h00;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [15:0] div;
    logic [23:0] len;
    int          exp_bytes;
    logic        exp_done;
  } vec_t;
  vec_t vecs[5];

  capture_trigger dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_in   (sample_in),
    .arm         (arm),
    .abort       (abort),
    .div         (div),
    .trig_mask   (trig_mask),
    .trig_value  (trig_value),
    .trig_edge   (trig_edge),
    .capture_len (capture_len),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .busy        (busy),
    .armed       (armed),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pin(input int n);
    logic [7:0] b;
    b = n[7:0];
    return (b & ~force_mask) | (force_val & force_mask);
  endfunction

  // Drive the channel pins a little after each edge from the pattern.
  always @(posedge clk) begin
    #2;
    sample_in = pin(cyc);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Byte monitor: one line per byte, compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && valid_out) begin
      byte_cnt++;
      $display("byte cycle=%0d data=%02h", cyc, data_out);
      if (sb_en) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h at cycle %0d, required none", data_out, cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("byte_cycle", cyc, e.cyc);
          chk("byte_data", {24'h0, data_out}, {24'h0, e.data});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_until(input int target);
    while (cyc < target) tick(1);
  endtask

  // Expected bytes: the stb in cycle t samples the pin driven at t-2, output at t+1.
  task automatic push_exp(input int t0, input int n, input int per);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.cyc  = t0 + 1 + k * per;
      e.data = pin(t0 - 2 + k * per);
      sb_q.push_back(e);
    end
  endtask

  // Arm with a configuration, then scramble the config inputs.
  task automatic do_arm(input logic [15:0] d, input logic [7:0] m, input logic [7:0] v,
                        input logic e, input logic [23:0] l, output int a);
    div = d; trig_mask = m; trig_value = v; trig_edge = e; capture_len = l;
    arm = 1'b1;
    a = cyc;
    tick(1);
    arm = 1'b0;
    div = 16'hffff; trig_mask = 8'h5a; trig_value = 8'ha5; trig_edge = ~e; capture_len = 24'h7;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    chk({nm, "_timeout_busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int a;
    int l;
    int r;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int l;
    int r;

    vecs[0] = '{div: 16'd0, len: 24'd1, exp_bytes: 4,  exp_done: 1'b1};
    vecs[1] = '{div: 16'd3, len: 24'd2, exp_bytes: 8,  exp_done: 1'b1};
    vecs[2] = '{div: 16'd1, len: 24'd3, exp_bytes: 12, exp_done: 1'b1};
    vecs[3] = '{div: 16'd0, len: 24'd0, exp_bytes: 0,  exp_done: 1'b1};
    vecs[4] = '{div: 16'd2, len: 24'd1, exp_bytes: 4,  exp_done: 1'b1};

    // Reset state.
    tick(3);
    chk("reset_outputs", {20'h0, valid_out, data_out, busy, armed, done}, 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Table: mask=0 triggers on the first strobe, then 4*len bytes every div+1 clocks.
    for (int i = 0; i < 5; i++) begin
      byte_cnt = 0;
      do_arm(vecs[i].div, 8'h00, 8'h00, 1'b0, vecs[i].len, a);
      push_exp(a + 1, vecs[i].exp_bytes, int'(vecs[i].div) + 1);
      wait_idle($sformatf("vec%0d", i), 4 * int'(vecs[i].len) * (int'(vecs[i].div) + 1) + 10);
      tick(2);
      chk($sformatf("vec%0d_bytes", i), byte_cnt, vecs[i].exp_bytes);
      chk($sformatf("vec%0d_done", i), {31'h0, done}, {31'h0, vecs[i].exp_done});
      chk($sformatf("vec%0d_sb_empty", i), sb_q.size(), 0);
    end

    // Level trigger on ch0 going high, div=3, len=2.
    byte_cnt = 0;
    force_mask = 8'h01; force_val = 8'h00;
    tick(3);
    do_arm(16'd3, 8'h01, 8'h01, 1'b0, 24'd2, a);
    tick_until(a + 10);
    force_val = 8'h01;
    push_exp(a + 13, 8, 4);
    wait_idle("level_trig", 60);
    tick(2);
    chk("level_trig_bytes", byte_cnt, 8);
    chk("level_trig_done", {31'h0, done}, 32'h1);
    chk("level_trig_sb_empty", sb_q.size(), 0);

    // Edge trigger on ch7: high at arm must not fire; low then high fires.
    byte_cnt = 0;
    force_mask = 8'h80; force_val = 8'h80;
    tick(3);
    do_arm(16'd0, 8'h80, 8'h80, 1'b1, 24'd1, a);
    tick(8);
    chk("edge_still_armed", {31'h0, armed}, 32'h1);
    chk("edge_no_bytes", byte_cnt, 0);
    force_val = 8'h00;
    l = cyc;
    tick(3);
    force_val = 8'h80;
    r = cyc;
    push_exp(r + 2, 4, 1);
    wait_idle("edge_trig", 30);
    tick(2);
    chk("edge_trig_bytes", byte_cnt, 4);
    chk("edge_trig_done", {31'h0, done}, 32'h1);
    chk("edge_sb_empty", sb_q.size(), 0);
    force_mask = 8'h00; force_val = 8'h00;

    // Mid-word abort after byte 6 of 12: word completes, 8 bytes, back to IDLE.
    byte_cnt = 0;
    do_arm(16'd1, 8'h00, 8'h00, 1'b0, 24'd3, a);
    push_exp(a + 1, 8, 2);
    tick_until(a + 12);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick_until(a + 24);
    chk("abort_bytes", byte_cnt, 8);
    chk("abort_state", {29'h0, busy, armed, done}, 32'h0);
    chk("abort_sb_empty", sb_q.size(), 0);

    // Arm and abort together from IDLE: abort wins.
    byte_cnt = 0;
    arm = 1'b1; abort = 1'b1; capture_len = 24'd1;
    tick(1);
    arm = 1'b0; abort = 1'b0;
    chk("arm_abort_busy", {31'h0, busy}, 32'h0);
    tick(6);
    chk("arm_abort_idle", {29'h0, busy, armed, done}, 32'h0);
    chk("arm_abort_bytes", byte_cnt, 0);

    // len=0: ARMED for one cycle, then DONE with no bytes.
    do_arm(16'd0, 8'h00, 8'h00, 1'b0, 24'd0, a);
    chk("len0_armed", {31'h0, armed}, 32'h1);
    tick(1);
    chk("len0_done", {30'h0, busy, done}, 32'h1);
    tick(3);
    chk("len0_bytes", byte_cnt, 0);

    // Reset in the middle of a capture, then a clean word-aligned capture.
    sb_en = 1'b0;
    do_arm(16'd0, 8'h00, 8'h00, 1'b0, 24'd4, a);
    tick(5);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {20'h0, valid_out, data_out, busy, armed, done}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    sb_q.delete();
    sb_en = 1'b1;
    byte_cnt = 0;
    do_arm(16'd0, 8'h00, 8'h00, 1'b0, 24'd1, a);
    push_exp(a + 1, 4, 1);
    wait_idle("post_reset", 20);
    tick(2);
    chk("post_reset_bytes", byte_cnt, 4);
    chk("post_reset_done", {31'h0, done}, 32'h1);
    chk("post_reset_sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
